// File: rtl/diag_input_sequencer.sv
// diag_input_sequencer: byte-stream front end for the binary-diagnostic solver.
// Assembles ASCII '0'/'1' lines into DIGITS-bit words, feeds them to the
// solver one per EMIT cycle, then captures the solver's solution at end of input.
module diag_input_sequencer #(
    parameter int DIGITS = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              solver_reset,
    output logic              solver_enable,
    output logic [DIGITS-1:0] solver_value,
    input  logic [31:0]       solver_solution,
    output logic [31:0]       result,
    output logic [31:0]       lines,
    output logic              done,
    output logic              error
);

    localparam int            CW   = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_COLLECT,
        S_EMIT,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [DIGITS-1:0] shift_q, shift_d;
    logic [CW-1:0]     count_q, count_d;
    logic              last_q, last_d;
    logic [31:0]       lines_q, lines_d;
    logic [31:0]       result_q, result_d;

    // Per-byte decode scratch, only meaningful in COLLECT.
    logic              is_digit;
    logic              is_lf;
    logic              is_cr;
    logic              bad;
    logic              line_done;
    logic [CW-1:0]     cnt_n;
    logic [DIGITS-1:0] shf_n;

    // State and datapath registers; reset lands in CLEAR with everything zeroed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_CLEAR;
            shift_q  <= '0;
            count_q  <= '0;
            last_q   <= 1'b0;
            lines_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            last_q   <= last_d;
            lines_q  <= lines_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: byte parsing in COLLECT, line emission, result capture.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        last_d    = last_q;
        lines_d   = lines_q;
        result_d  = result_q;
        is_digit  = (in_data == CH_0) || (in_data == CH_1);
        is_lf     = (in_data == CH_LF);
        is_cr     = (in_data == CH_CR);
        bad       = 1'b0;
        line_done = 1'b0;
        cnt_n     = count_q;
        shf_n     = shift_q;

        if (start) begin
            // Clearing on entry keeps lines/result at zero for the whole CLEAR cycle.
            state_d  = S_CLEAR;
            shift_d  = '0;
            count_d  = '0;
            last_d   = 1'b0;
            lines_d  = '0;
            result_d = '0;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    state_d = S_COLLECT;
                end

                S_COLLECT: begin
                    if (in_valid) begin
                        if (is_digit) begin
                            if (count_q == FULL) begin
                                bad = 1'b1;
                            end else begin
                                shf_n = {shift_q[DIGITS-2:0], in_data[0]};
                                cnt_n = count_q + CW'(1);
                            end
                        end else if (is_lf) begin
                            if (count_q == FULL) begin
                                line_done = 1'b1;
                            end else if (count_q != '0) begin
                                bad = 1'b1;
                            end
                        end else if (!is_cr) begin
                            bad = 1'b1;
                        end

                        shift_d = shf_n;
                        count_d = cnt_n;

                        // Malformed input wins over end-of-input handling.
                        if (bad) begin
                            state_d = S_ERROR;
                        end else if (in_last) begin
                            if (cnt_n == FULL) begin
                                state_d = S_EMIT;
                                last_d  = 1'b1;
                            end else if (cnt_n == '0) begin
                                state_d = S_WAIT;
                            end else begin
                                state_d = S_ERROR;
                            end
                        end else if (line_done) begin
                            state_d = S_EMIT;
                        end
                    end
                end

                S_EMIT: begin
                    lines_d = (lines_q == '1) ? lines_q : lines_q + 32'd1;
                    count_d = '0;
                    state_d = last_q ? S_WAIT : S_COLLECT;
                end

                S_WAIT: begin
                    // Solver has absorbed the last line by now; sample its answer.
                    result_d = solver_solution;
                    state_d  = S_DONE;
                end

                S_DONE: begin
                    state_d = S_DONE;
                end

                S_ERROR: begin
                    state_d = S_ERROR;
                end

                default: begin
                    state_d = S_CLEAR;
                end
            endcase
        end
    end

    // Outputs are pure state decodes so in_ready never depends on in_valid.
    always_comb begin
        in_ready      = (state_q == S_COLLECT);
        solver_reset  = (state_q == S_CLEAR);
        solver_enable = (state_q == S_EMIT);
        solver_value  = (state_q == S_EMIT) ? shift_q : '0;
        result        = result_q;
        lines         = lines_q;
        done          = (state_q == S_DONE);
        error         = (state_q == S_ERROR);
    end

endmodule

// File: tb/tb_diag_input_sequencer.sv
// Bench for diag_input_sequencer: directed byte streams, a behavioural
// diagnostic solver, and a scoreboard monitor that checks emitted words and
// timed status expectations.
module tb_diag_input_sequencer;

    localparam int          DIGITS = 12;
    localparam logic [31:0] RES3   = 32'd979200;

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              solver_reset;
    logic              solver_enable;
    logic [DIGITS-1:0] solver_value;
    logic [31:0]       solver_solution;
    logic [31:0]       result;
    logic [31:0]       lines;
    logic              done;
    logic              error;

    diag_input_sequencer #(.DIGITS(DIGITS)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .solver_reset    (solver_reset),
        .solver_enable   (solver_enable),
        .solver_value    (solver_value),
        .solver_solution (solver_solution),
        .result          (result),
        .lines           (lines),
        .done            (done),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural solver: per-bit ones count, solution = gamma * epsilon.
    int                ones [DIGITS];
    int                nseen = 0;
    logic [DIGITS-1:0] gamma, eps;

    always @(posedge clk) begin
        if (solver_reset) begin
            for (int i = 0; i < DIGITS; i++) ones[i] <= 0;
            nseen <= 0;
        end else if (solver_enable) begin
            for (int i = 0; i < DIGITS; i++) ones[i] <= ones[i] + (solver_value[i] ? 1 : 0);
            nseen <= nseen + 1;
        end
    end

    always_comb begin
        gamma = '0;
        eps   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (2 * ones[i] > nseen) gamma[i] = 1'b1;
            else                     eps[i]   = 1'b1;
        end
        solver_solution = 32'(gamma) * 32'(eps);
    end

    // Scoreboard state.
    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t              chkq [$];
    logic [DIGITS-1:0] expq [$];
    int                n_tests = 0;
    int                n_fail  = 0;
    bit                gap_en  = 1'b0;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            0:       return {31'd0, done};
            1:       return {31'd0, error};
            2:       return lines;
            3:       return result;
            4:       return {31'd0, in_ready};
            5:       return {31'd0, solver_reset};
            6:       return 32'(expq.size());
            7:       return {31'd0, solver_enable};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input int at, input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.cyc  = at;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        chkq.push_back(c);
    endtask

    // Monitor: pops an expected word on every enable pulse, and evaluates
    // status expectations whose cycle has arrived.
    chk_t              mon_c;
    logic [DIGITS-1:0] mon_e;
    logic [31:0]       mon_act;

    always @(negedge clk) begin
        if (solver_enable === 1'b1) begin
            n_tests++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL enable_unexpected: got pulse value %h, required no pulse", solver_value);
            end else begin
                mon_e = expq.pop_front();
                if (solver_value !== mon_e) begin
                    n_fail++;
                    $display("FAIL solver_value: got %h, required %h", solver_value, mon_e);
                end
            end
        end
        while (chkq.size() > 0 && chkq[0].cyc <= cyc) begin
            mon_c   = chkq.pop_front();
            mon_act = sample(mon_c.sel);
            n_tests++;
            if (mon_act !== mon_c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, required %0d (cycle %0d)", mon_c.name, mon_act, mon_c.exp, cyc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last, output int t);
        int n;
        int g;
        n = 0;
        g = gap_en ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < g; i++) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk(cyc, 4, 32'd1, "send_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        t = cyc;
    endtask

    task automatic send_str(input string s, input bit last, output int t);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last && (i == s.len() - 1), t);
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
        chk(s,     5, 32'd1, "start_solver_reset");
        chk(s,     2, 32'd0, "start_lines");
        chk(s,     1, 32'd0, "start_error");
        chk(s,     0, 32'd0, "start_done");
        chk(s,     4, 32'd0, "start_in_ready");
        chk(s + 1, 5, 32'd0, "start_solver_reset_off");
        chk(s + 1, 4, 32'd1, "start_in_ready_on");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int s;
        reset    = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk(cyc, 4, 32'd0, "rst_in_ready");
        chk(cyc, 5, 32'd1, "rst_solver_reset");
        chk(cyc, 2, 32'd0, "rst_lines");
        chk(cyc, 3, 32'd0, "rst_result");
        chk(cyc, 0, 32'd0, "rst_done");
        chk(cyc, 1, 32'd0, "rst_error");
        chk(cyc, 7, 32'd0, "rst_enable");
        @(posedge clk);
        #1;
        reset = 1'b1;
        s = cyc;
        chk(s,     5, 32'd1, "rel_solver_reset");
        chk(s + 1, 4, 32'd1, "rel_in_ready");
        chk(s + 1, 5, 32'd0, "rel_solver_reset_off");

        // Three LF-terminated lines, in_last on final LF.
        expq.push_back(12'hF00);
        expq.push_back(12'hF00);
        expq.push_back(12'h0F0);
        send_str("111100000000\n", 1'b0, t);
        chk(t,     4, 32'd0, "t1_bubble");
        chk(t + 1, 4, 32'd1, "t1_ready_back");
        send_str("111100000000\n", 1'b0, t);
        send_str("000011110000\n", 1'b1, t);
        chk(t + 1, 0, 32'd0, "t1_done_early");
        chk(t + 2, 0, 32'd1, "t1_done");
        chk(t + 2, 3, RES3,  "t1_result");
        chk(t + 2, 2, 32'd3, "t1_lines");
        chk(t + 2, 6, 32'd0, "t1_pulses");
        repeat (4) @(posedge clk);
        #1;

        // CRLF, blank line, final line ends on its 12th digit with in_last.
        do_start(s);
        expq.push_back(12'hF00);
        expq.push_back(12'hF00);
        expq.push_back(12'h0F0);
        send_str("111100000000\r\n", 1'b0, t);
        send_str("\r\n", 1'b0, t);
        send_str("111100000000\r\n", 1'b0, t);
        send_str("000011110000", 1'b1, t);
        chk(t,     7, 32'd1, "t2_emit_on_digit");
        chk(t + 2, 0, 32'd1, "t2_done");
        chk(t + 2, 3, RES3,  "t2_result");
        chk(t + 2, 2, 32'd3, "t2_lines");
        repeat (4) @(posedge clk);
        #1;

        // Illegal byte in line 2.
        do_start(s);
        expq.push_back(12'hF00);
        send_str("111100000000\n", 1'b0, t);
        send_str("1x", 1'b0, t);
        chk(t,     1, 32'd1, "t3_error");
        chk(t,     4, 32'd0, "t3_in_ready");
        chk(t,     0, 32'd0, "t3_done");
        chk(t,     2, 32'd1, "t3_lines");
        chk(t + 3, 1, 32'd1, "t3_error_held");
        chk(t + 3, 3, 32'd0, "t3_result");
        repeat (4) @(posedge clk);
        #1;

        // 13 digits, then 11 digits + LF.
        do_start(s);
        send_str("111111111111", 1'b0, t);
        chk(t, 1, 32'd0, "t4_12_ok");
        chk(t, 4, 32'd1, "t4_12_ready");
        send_byte(8'h31, 1'b0, t);
        chk(t, 1, 32'd1, "t4_13th_error");
        repeat (2) @(posedge clk);
        #1;
        do_start(s);
        send_str("11111111111", 1'b0, t);
        chk(t, 1, 32'd0, "t4_11_ok");
        send_byte(8'h0A, 1'b0, t);
        chk(t, 1, 32'd1, "t4_short_error");
        chk(t, 2, 32'd0, "t4_lines");
        repeat (2) @(posedge clk);
        #1;

        // in_last on a CR with no partial line.
        do_start(s);
        expq.push_back(12'hF00);
        send_str("111100000000\n", 1'b0, t);
        send_byte(8'h0D, 1'b1, t);
        chk(t,     0, 32'd0, "t7_wait");
        chk(t + 1, 0, 32'd1, "t7_done");
        chk(t + 1, 3, RES3,  "t7_result");
        chk(t + 1, 2, 32'd1, "t7_lines");
        repeat (3) @(posedge clk);
        #1;

        // Gappy in_valid, abort mid-line, then a clean gappy run.
        do_start(s);
        gap_en = 1'b1;
        expq.push_back(12'hF00);
        send_str("111100000000\n", 1'b0, t);
        send_str("0000", 1'b0, t);
        do_start(s);
        expq.push_back(12'hF00);
        expq.push_back(12'hF00);
        expq.push_back(12'h0F0);
        send_str("111100000000\n", 1'b0, t);
        send_str("111100000000\n", 1'b0, t);
        send_str("000011110000\n", 1'b1, t);
        chk(t + 2, 0, 32'd1, "t5_done");
        chk(t + 2, 3, RES3,  "t5_result");
        chk(t + 2, 2, 32'd3, "t5_lines");
        gap_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset asserted during EMIT of the second line.
        do_start(s);
        expq.push_back(12'hF00);
        send_str("111100000000\n", 1'b0, t);
        send_str("000011110000\n", 1'b0, t);
        reset = 1'b0;
        chk(t, 7, 32'd0, "t6_enable_async");
        chk(t, 5, 32'd1, "t6_solver_reset_async");
        chk(t, 2, 32'd0, "t6_lines_async");
        chk(t, 4, 32'd0, "t6_in_ready_async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        s = cyc;
        chk(s,     5, 32'd1, "t6_rel_solver_reset");
        chk(s + 1, 4, 32'd1, "t6_rel_in_ready");

        repeat (3) @(posedge clk);
        #1;
        chk(cyc, 6, 32'd0, "drain_pending_pulses");
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/diag_input_sequencer.md
# diag_input_sequencer

Front-end controller for the binary-diagnostic solver. Accepts the puzzle input as an ASCII byte stream over a valid/ready handshake, assembles each line of '0'/'1' digits into a DIGITS-bit word, and sequences the solver's `reset`/`enable`/`value` inputs. At end of input it waits for the solver to settle, then captures its `solution` into a held result register. It sits between the byte-stream source and the solver instance.

## Interface
- `DIGITS`, 12: digits per line; equals the solver's value width.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: abort any run, clear solver, begin a new run.
- `in_data`  in  8  ASCII byte.
- `in_valid`  in  1  byte present.
- `in_last`  in  1  qualifies `in_data` as the final byte of the input.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `solver_reset`  out  1  to solver `reset` (active-high, synchronous at the solver).
- `solver_enable`  out  1  to solver `enable`.
- `solver_value`  out  DIGITS  to solver `value`; bit DIGITS-1 is the first digit of the line.
- `solver_solution`  in  32  from solver `solution`.
- `result`  out  32  captured solution.
- `lines`  out  32  number of lines emitted to the solver in the current run.
- `done`  out  1  result valid; held.
- `error`  out  1  malformed input; held.

## Operation
- States: CLEAR, COLLECT, EMIT, WAIT, DONE, ERROR. Reset enters CLEAR.
- Reset values: `in_ready`=0, `solver_enable`=0, `solver_reset`=1 (CLEAR), `solver_value`=0, `result`=0, `lines`=0, `done`=0, `error`=0; digit count and shift register 0.
- CLEAR: `solver_reset`=1 for exactly one cycle; clears `lines`, `done`, `error`, shift register, digit count; then COLLECT.
- COLLECT: `in_ready`=1. Per accepted byte:
  - '0' (0x30) / '1' (0x31): shift in at LSB, count+1. Accepting digit number DIGITS+1 of a line → ERROR.
  - '\n' (0x0A): count==DIGITS → EMIT; count==0 → ignored (blank line); otherwise → ERROR.
  - '\r' (0x0D): ignored.
  - any other byte → ERROR.
  - `in_last` with the byte: after applying the byte, a complete line pending (count==DIGITS, including a digit that completes it without a trailing '\n') → EMIT with last-flag set; count==0 → WAIT; partial line → ERROR. Error conditions take priority over `in_last`.
- EMIT: one cycle; `solver_enable`=1, `solver_value`=shift register, `in_ready`=0; `lines`+1, count cleared; then WAIT if last-flag else COLLECT.
- WAIT: one cycle, `in_ready`=0; `result` <= `solver_solution` on exit; → DONE.
- DONE: `done`=1, `in_ready`=0; holds until `start`.
- ERROR: `error`=1, `in_ready`=0, `result` unchanged (0 after CLEAR); holds until `start`.
- `start` in any state → CLEAR next cycle; wins over a simultaneous byte (byte not accepted, since `in_ready` drops the following cycle; source must treat the run as aborted).
- `solver_enable` is 0 in every state except EMIT; `solver_value` only meaningful while `solver_enable`=1.
- `lines` saturates at 0xFFFF_FFFF.
- Reset assertion mid-run: immediate return to reset values; run lost.

## Timing
- Line terminator accepted in cycle t → `solver_enable`=1 in t+1 → `in_ready`=1 again in t+2 (one bubble per line).
- Final line terminator with `in_last` at t → EMIT t+1, WAIT t+2, `done`=1 and `result` valid from t+3.
- `in_last` on a blank/'\r' byte at t (count 0) → WAIT t+1, `done` from t+2.
- `start` at t → CLEAR t+1 (`solver_reset`=1), COLLECT t+2 (`in_ready`=1).
- `in_ready` does not depend combinationally on `in_valid`.

## Test plan
- Reset release then 3 lines "111100000000\n","111100000000\n","000011110000\n" (last byte `in_last`) with solver attached → `lines`=3, `result`=3840*255=979200, `done`=1 three cycles after the final byte, exactly three one-cycle `solver_enable` pulses with values 0xF00, 0xF00, 0x0F0.
- Same input with "\r\n" terminators, a blank line inserted mid-stream, final line without '\n' but with `in_last` on its 12th digit → identical result and `lines`=3.
- Byte 'x' in line 2 → `error`=1 next cycle, `in_ready`=0, `done`=0, `lines`=1; then `start` → `error`=0, `lines`=0, one `solver_reset` pulse.
- 13 digits before '\n' → ERROR on the 13th digit; 11 digits then '\n' → ERROR on the '\n'.
- `in_valid` toggled randomly and `start` pulsed mid-line → no byte lost or duplicated in runs that finish; aborted run leaves no emitted partial line, new run from CLEAR gives correct result.
- Reset asserted during EMIT → all outputs at reset values asynchronously; `solver_reset`=1 on release.
